// File: rtl/word_packer.sv
// word_packer: gathers N_WORDS signed words into one packed frame for the
// downstream multiply/adder-tree stage, with ready/valid on both sides.
module word_packer #(
  parameter int unsigned N_WORDS = 12,
  parameter int unsigned NB_DATA = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NB_DATA-1:0]                 i_data,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic                               i_clear,
  output logic [N_WORDS*NB_DATA-1:0]         o_data,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [$clog2(N_WORDS+1)-1:0]       o_count
);

  localparam int unsigned CW = $clog2(N_WORDS + 1);
  localparam int unsigned FW = N_WORDS * NB_DATA;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   data_q,  data_d;
  logic [CW-1:0]   count_q, count_d;
  logic            accept;
  logic [CW-1:0]   slot;
  logic [CW-1:0]   count_inc;

  // Ready depends only on state and downstream ready, never on i_valid.
  assign o_ready   = (state_q == FILL) || i_ready;
  assign accept    = i_valid && o_ready;
  // A word accepted while a frame is held starts the next frame at slot 0.
  assign slot      = (state_q == FULL) ? '0 : count_q;
  assign count_inc = slot + CW'(1);

  // Next-state: clear beats handshake; a held frame is released by i_ready.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (i_clear) begin
      state_d = FILL;
      count_d = '0;
    end else if (accept) begin
      for (int unsigned s = 0; s < N_WORDS; s++) begin
        if (slot == CW'(s)) begin
          data_d[s*NB_DATA +: NB_DATA] = i_data;
        end
      end
      count_d = count_inc;
      state_d = (count_inc == CW'(N_WORDS)) ? FULL : FILL;
    end else if ((state_q == FULL) && i_ready) begin
      state_d = FILL;
      count_d = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FILL;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = (state_q == FULL);
  assign o_count = count_q;

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter N_WORDS, default 12: number of signed words per output frame; legal range is 1 or more.
REQ-002 SHALL have parameter NB_DATA, default 8: width in bits of each signed word.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_data, input, NB_DATA bits: incoming signed word.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data is valid this cycle.
REQ-007 SHALL have port o_ready, output, 1 bit: the block accepts i_data this cycle.
REQ-008 SHALL have port i_clear, input, 1 bit: synchronous discard of any partial or held frame.
REQ-009 SHALL have port o_data, output, N_WORDS*NB_DATA bits: packed frame feeding the downstream multiply/adder-tree stage.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data holds a complete frame.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream consumes the frame this cycle.
REQ-012 SHALL have port o_count, output, $clog2(N_WORDS+1) bits: number of words stored in the current frame.

Function
REQ-013 SHALL implement two states: FILL (collecting words) and FULL (frame held).
REQ-014 SHALL define a word as accepted when i_valid=1 and o_ready=1 at a rising clock edge.
REQ-015 SHALL drive o_ready=1 in FILL, drive o_ready=i_ready in FULL, and never derive o_ready combinationally from i_valid.
REQ-016 SHALL write the k-th accepted word of a frame (k=0 first) into o_data[(k+1)*NB_DATA-1 -: NB_DATA], unmodified, with no sign extension.
REQ-017 SHALL, in FILL, increment o_count by one on each accepted word and hold o_count on cycles without acceptance.
REQ-018 SHALL move FILL->FULL on acceptance of word N_WORDS-1, setting o_valid=1 and o_count=N_WORDS from the next cycle.
REQ-019 SHALL give a latency of exactly one cycle: o_valid rises on the edge that accepts the last word.
REQ-020 SHALL, in FULL with i_ready=0, hold o_data, o_valid and o_count stable and ignore i_valid.
REQ-021 SHALL, in FULL with i_ready=1 and i_valid=0, move to FILL with o_valid=0 and o_count=0.
REQ-022 SHALL, in FULL with i_ready=1 and i_valid=1, write the word into slot 0, set o_count=1, set o_valid=0 and move to FILL; this sustains 1 word/cycle with no bubble.
REQ-023 SHALL leave slots not yet rewritten in the current frame at their previous values; o_data is meaningful only while o_valid=1.
REQ-024 SHALL, when N_WORDS=1, go directly FILL->FULL on every accepted word.
REQ-025 SHALL, when i_clear=1 at an edge, set state to FILL, o_count=0 and o_valid=0, and discard any concurrent input word or held frame; o_data is not cleared.
REQ-026 SHALL apply the priority reset > i_clear > handshake.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, set state=FILL, o_data=0, o_valid=0 and o_count=0; o_ready is then 1.
REQ-028 SHALL, on reset asserted mid-frame, discard the partial frame and accept no word in that cycle.

Verification
REQ-029 SHALL cover, with N_WORDS=12 and NB_DATA=8: reset, then words 0x01..0x0C back-to-back with i_ready=1 -> o_valid=1 for exactly one cycle after the 12th word, o_data[7:0]=0x01 ... o_data[95:88]=0x0C, o_count=12.
REQ-030 SHALL cover: frame FULL, i_ready=0 for 5 cycles with i_valid=1 -> o_ready=0, o_data and o_count unchanged; then i_ready=1 with i_data=0x80 -> next cycle o_data[7:0]=0x80, o_count=1, o_valid=0.
REQ-031 SHALL cover: words with random i_valid gaps -> o_count increments only on accepted cycles, and the frame is correct after the 12th accepted word.
REQ-032 SHALL cover: 7 words (0xF0..0xF6), then i_clear=1 together with i_valid=1 -> o_count=0 and the word is dropped; the next 12 words (0x10..0x1B) form a frame containing no 0xF* value.
REQ-033 SHALL cover: reset=0 for one cycle at o_count=5 -> o_count=0, o_valid=0, o_data=0; the following 12 words produce a correct frame.
REQ-034 SHALL cover: 36 consecutive words 0x00..0x23 with i_ready=1 -> three frames, each with o_valid high exactly one cycle, and frame 2 slot 0=0x0C and frame 3 slot 11=0x23.
